chip_ahb_master: RTL

//  CHIP-side initiator for the simplified AHB link to the FPGA/DDR responder. One instance per port.

---
 rtl/chip_ahb_pkg.sv | 26 ++
 rtl/chip_ahb_rdfifo.sv | 60 ++++++
 rtl/chip_ahb_master.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/chip_ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip_ahb_pkg
//  Description : Shared constants and types for the CHIP-side AHB initiator.
//                HTRANS encodings, fixed HSIZE/HBURST values and the
//                initiator state enumeration.
//  Revision    : 1.0  initial release
// ============================================================================
package chip_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HSIZE_FULL    = 2'b11;
    localparam logic [1:0] HBURST_INCR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/chip_ahb_rdfifo.sv
`default_nettype none
// ============================================================================
//  Module      : chip_ahb_rdfifo
//  Description : 2-entry synchronous skid FIFO for read beats.
//  Ports       : clk_i/rst_n_i   clock, async active-low reset
//                push_i/push_dat_i  write side (ignored when full and not popping)
//                pop_i           consume head (ignored when empty)
//                head_o/vld_o    head entry and non-empty flag
//                cnt_o           occupancy 0..2
//  Revision    : 1.0  initial release
// ============================================================================
module chip_ahb_rdfifo #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  vld_o,
    output logic [1:0]            cnt_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  w_push;
    logic                  w_pop;

    always_comb begin
        w_pop  = pop_i & (cnt_q != 2'd0);
        // A full FIFO can still accept when the head leaves in the same cycle.
        w_push = push_i & ((cnt_q != 2'd2) | w_pop);
        wptr_d = wptr_q ^ w_push;
        rptr_d = rptr_q ^ w_pop;
        cnt_d  = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (w_push) mem_q[wptr_q] <= push_dat_i;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o = mem_q[rptr_q];
    assign vld_o  = (cnt_q != 2'd0);
    assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/chip_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module      : chip_ahb_master
//  Description : CHIP-side AHB initiator. Converts a {dir, addr, len} command
//                into a pipelined INCR burst, streaming write beats from a
//                valid/ready source and read beats into a 2-entry skid FIFO.
//  Ports       : cmd_*_i/cmd_rdy_o  burst command handshake
//                wr_*               write-beat valid/ready source
//                rd_*               read-beat valid/ready sink (FIFO head)
//                done_o/err_o       1-cycle completion pulse + error flag
//                H*_o / H*_i        AHB initiator interface
//  Revision    : 1.0  initial release
// ============================================================================
module chip_ahb_master
    import chip_ahb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 512,
    parameter int         LEN_WIDTH  = 16,
    parameter logic [2:0] HPORT_VAL  = 3'b011
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_vld_i,
    output logic                  cmd_rdy_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wr_vld_i,
    output logic                  wr_rdy_o,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    output logic                  rd_vld_o,
    input  logic                  rd_rdy_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] HADDR_o,
    output logic                  HWRITE_o,
    output logic [1:0]            HSIZE_o,
    output logic [1:0]            HBURST_o,
    output logic [2:0]            HPORT_o,
    output logic                  HMASTERLOCK_o,
    output logic [1:0]            HTRANS_o,
    output logic [DATA_WIDTH-1:0] HWDATA_o,
    input  logic                  HREADY_i,
    input  logic                  HRESP_i,
    input  logic [DATA_WIDTH-1:0] HRDATA_i
);

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;     // address phases still to issue
    logic                  dir_q, dir_d;         // 1 = write
    logic                  first_q, first_d;     // no address phase issued yet
    logic                  dphase_q, dphase_d;   // a data phase is outstanding
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic                  err_seen_q, err_seen_d;
    logic                  done_q, done_d;
    logic                  done_err_q, done_err_d;

    logic [1:0]            w_fifo_cnt;
    logic [2:0]            w_occ;
    logic                  w_beats_nz;
    logic                  w_can_issue;
    logic [1:0]            w_htrans;
    logic                  w_addr_acc;
    logic                  w_data_done;
    logic                  w_err_hit;
    logic                  w_rd_push;
    logic                  w_wr_rdy;
    logic                  w_wr_pop;

    chip_ahb_rdfifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdfifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (w_rd_push),
        .push_dat_i (HRDATA_i),
        .pop_i      (rd_rdy_i),
        .head_o     (rd_dat_o),
        .vld_o      (rd_vld_o),
        .cnt_o      (w_fifo_cnt)
    );

    // Bus-side issue decision and handshake qualifiers.
    always_comb begin
        // Read slots already claimed: buffered beats plus a read in flight.
        w_occ       = {1'b0, w_fifo_cnt} + {2'b00, dphase_q & ~dir_q};
        w_beats_nz  = (beats_q != '0);
        w_can_issue = w_beats_nz & (dir_q ? wr_vld_i : (w_occ < 3'd2));

        w_htrans = HTRANS_IDLE;
        if (state_q == ST_ADDR) begin
            if (w_can_issue) w_htrans = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
            else             w_htrans = first_q ? HTRANS_IDLE   : HTRANS_BUSY;
        end

        w_addr_acc  = w_htrans[1] & HREADY_i;
        w_data_done = dphase_q & HREADY_i;
        w_err_hit   = w_data_done & HRESP_i;
        // Error responses carry no valid data, so they are not buffered.
        w_rd_push   = w_data_done & ~dir_q & ~HRESP_i;
        w_wr_rdy    = (state_q == ST_ADDR) & HREADY_i & dir_q & w_beats_nz;
        w_wr_pop    = w_wr_rdy & wr_vld_i;
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        dir_d      = dir_q;
        first_d    = first_q;
        hwdata_d   = hwdata_q;
        err_seen_d = err_seen_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        dphase_d   = w_addr_acc | (dphase_q & ~HREADY_i);

        if (w_addr_acc) begin
            addr_d  = addr_q + STEP;
            beats_d = beats_q - LEN_ONE;
            first_d = 1'b0;
        end
        if (w_wr_pop) hwdata_d = wr_dat_i;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_vld_i) begin
                    dir_d      = cmd_write_i;
                    addr_d     = cmd_addr_i;
                    beats_d    = cmd_len_i;
                    first_d    = 1'b1;
                    err_seen_d = 1'b0;
                    if (cmd_len_i == '0) done_d  = 1'b1;
                    else                 state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_err_hit) begin
                    // Abandon the rest; a phase accepted this cycle still needs its data phase.
                    err_seen_d = 1'b1;
                    beats_d    = '0;
                    if (w_addr_acc) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end
                end else if (w_addr_acc && (beats_q == LEN_ONE)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_data_done) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    done_err_d = err_seen_q | HRESP_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            dir_q      <= 1'b0;
            first_q    <= 1'b0;
            dphase_q   <= 1'b0;
            hwdata_q   <= '0;
            err_seen_q <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            dir_q      <= dir_d;
            first_q    <= first_d;
            dphase_q   <= dphase_d;
            hwdata_q   <= hwdata_d;
            err_seen_q <= err_seen_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    // cmd_rdy is gated by reset so it reads 0 while reset is held.
    assign cmd_rdy_o     = (state_q == ST_IDLE) & rst_n_i;
    assign wr_rdy_o      = w_wr_rdy;
    assign done_o        = done_q;
    assign err_o         = done_err_q;
    assign HADDR_o       = addr_q;
    assign HWRITE_o      = dir_q;
    assign HSIZE_o       = HSIZE_FULL;
    assign HBURST_o      = HBURST_INCR;
    assign HPORT_o       = HPORT_VAL;
    assign HMASTERLOCK_o = 1'b0;
    assign HTRANS_o      = w_htrans;
    assign HWDATA_o      = hwdata_q;

endmodule
`default_nettype wire
